edge_debounce_mc: RTL

- Multi-channel debounced edge detector; the parametrised successor of the team's single-flop "a & ~b" registered-gate block.
- Each of CH asynchronous inputs is:
  - synchronised through two flops,
  - debounced by a per-channel stability counter,
  - reduced to a registered filtered level plus one-cycle rise and fall pulses.
- A saturating aggregate edge counter sits behind all channels.
- Sits between board-level inputs (buttons, switches, external strobes) and control FSMs.

---
 rtl/edge_debounce_mc_pkg.sv | 24 ++
 rtl/edge_debounce_ch.sv | 75 +++++++
 rtl/edge_debounce_mc.sv | 80 ++++++++
 3 files changed

// File: rtl/edge_debounce_mc_pkg.sv
// Shared types, defaults and helpers for the multi-channel debounced
// edge detector.
package edge_debounce_mc_pkg;

    // Default parameter values used by the top level.
    localparam int CH_DEF     = 4;
    localparam int DB_CNT_DEF = 16;
    localparam int TOT_W_DEF  = 16;

    // Per-channel event decided by the debounce logic for the next cycle.
    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_RISE = 2'd1,
        EV_FALL = 2'd2
    } ch_evt_e;

    // Counter width helper: max(1, $clog2(n)).
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_debounce_ch.sv
// One debounce channel: two-flop synchroniser, stability counter and
// registered filtered level with one-cycle rise/fall pulses.
//
// Ports:
//   clk   - system clock, posedge
//   rst_n - synchronous active-low reset
//   en    - debounce enable; low clears the count and holds lvl
//   din   - raw asynchronous input
//   lvl   - debounced level
//   rise  - one-cycle pulse when lvl goes 0->1
//   fall  - one-cycle pulse when lvl goes 1->0
module edge_debounce_ch
    import edge_debounce_mc_pkg::*;
#(
    parameter int DB_CNT = DB_CNT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(DB_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          lvl_d;
    ch_evt_e       evt;

    // Next-state decision. Only the second synchroniser stage is
    // ever looked at; s1 may be metastable.
    always_comb begin
        cnt_d = cnt;
        lvl_d = lvl;
        evt   = EV_NONE;
        if (!en) begin
            cnt_d = '0;
        end else if (s2 == lvl) begin
            // Any return to the current level restarts the count.
            cnt_d = '0;
        end else if (cnt == CNT_MAX) begin
            // DB_CNT consecutive differing cycles: accept new level.
            cnt_d = '0;
            lvl_d = s2;
            evt   = s2 ? EV_RISE : EV_FALL;
        end else begin
            cnt_d = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            cnt  <= cnt_d;
            lvl  <= lvl_d;
            rise <= (evt == EV_RISE);
            fall <= (evt == EV_FALL);
        end
    end

endmodule

// File: rtl/edge_debounce_mc.sv
// Multi-channel debounced edge detector with a saturating aggregate
// edge counter fed by the registered rise/fall pulses.
//
// Ports:
//   clk        - system clock, posedge
//   rst_n      - synchronous active-low reset
//   en         - debounce enable for all channels
//   din        - CH raw asynchronous inputs
//   clr        - synchronous clear of edge_total (wins over pulses)
//   lvl        - CH debounced levels
//   rise       - CH one-cycle rising-edge pulses
//   fall       - CH one-cycle falling-edge pulses
//   edge_total - saturating count of all rise+fall pulses
module edge_debounce_mc
    import edge_debounce_mc_pkg::*;
#(
    parameter int CH     = CH_DEF,
    parameter int DB_CNT = DB_CNT_DEF,
    parameter int TOT_W  = TOT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CH-1:0]    din,
    input  logic             clr,
    output logic [CH-1:0]    lvl,
    output logic [CH-1:0]    rise,
    output logic [CH-1:0]    fall,
    output logic [TOT_W-1:0] edge_total
);

    // Popcount width: enough to hold the value CH.
    localparam int PW = cnt_width(CH + 1);

    logic [CH-1:0]    hits;
    logic [PW-1:0]    n;
    logic [TOT_W:0]   sum;
    logic [TOT_W-1:0] total_d;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_debounce_ch #(
            .DB_CNT (DB_CNT)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .din   (din[i]),
            .lvl   (lvl[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign hits = rise | fall;

    always_comb begin
        n = '0;
        for (int i = 0; i < CH; i++) begin
            n = n + PW'(hits[i]);
        end
    end

    // One extra bit of headroom so the add cannot wrap before the
    // saturation test.
    always_comb begin
        sum     = {1'b0, edge_total} + (TOT_W + 1)'(n);
        total_d = sum[TOT_W] ? {TOT_W{1'b1}} : sum[TOT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_total <= '0;
        end else if (clr) begin
            edge_total <= '0;
        end else begin
            edge_total <= total_d;
        end
    end

endmodule
